rs232_tx: RTL and testbench
===========================

Name: rs232_tx

Overview:
- Byte-wide RS-232 serializer. Sits directly downstream of the memory dump sequencer and drives the board TXD pin.
- Accepts one byte per single-cycle start pulse and reports busy on a status line.
- Emits an 8N1 frame (8 data bits, LSB first, stop bits configurable) at a fixed integer clock divide.
- The upstream sequencer polls tx_status low, pulses tx_start for 1 cycle, then re-polls 2 cycles later. This block must satisfy that handshake with no lost or duplicated bytes.

Parameters:
- P_BAUD_DIV, 16'd434, clk cycles per bit (50 MHz / 115200). Legal range 2..65535.
- P_STOP_BITS, 1, number of stop bits. 2 selects two; any other value means one.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- tx_start  input  1  start request; sampled only in IDLE
- tx_data  input  8  byte to send; sampled on the same edge that accepts tx_start
- tx_status  output  1  busy: 1 from acceptance until the frame ends
- tx_done  output  1  1-cycle pulse on the edge that tx_status falls
- txd  output  1  serial line, idle high

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset values: state=IDLE, txd=1, tx_status=0, tx_done=0, shift register=8'h00, baud counter=0, bit counter=0.
- All outputs are registered. No combinational path from input to output.
- States:
  - IDLE: txd=1.
  - START: txd=0.
  - DATA: txd=shift[0]; shift right on each bit boundary.
  - PARITY: only with the optional feature; see below.
  - STOP: txd=1.
- IDLE -> START: on the edge where tx_start=1 in IDLE.
  - Same edge: tx_status<=1, txd<=0, shift<=tx_data, baud counter<=P_BAUD_DIV-1.
  - This guarantees tx_status is already 1 when the upstream re-polls 2 cycles after raising tx_start.
- Baud counter: 16-bit down-counter.
  - A bit boundary occurs on the edge where the counter is 0; the counter then reloads P_BAUD_DIV-1.
  - Every bit lasts exactly P_BAUD_DIV cycles.
- START -> DATA at the boundary. 3-bit counter counts data bits 0..7.
- DATA -> STOP at the boundary after bit 7 (or -> PARITY when the feature is enabled).
- STOP lasts P_STOP_BITS bit times. At its final boundary:
  - state<=IDLE, tx_status<=0, tx_done<=1 for 1 cycle.
  - txd stays 1.
- Frame length (tx_status high): exactly (1+8+P_STOP_BITS)*P_BAUD_DIV cycles; 10*P_BAUD_DIV for the default.
- tx_start while busy:
  - Ignored. tx_data changes while busy have no effect.
  - No queuing: a byte presented while busy is lost, by contract.
- tx_start held high:
  - IDLE is visible for exactly 1 cycle (tx_status=0), then the next frame starts.
  - Back-to-back frames therefore have a 1-cycle extra idle gap (txd=1).
- tx_start and the frame-end boundary in the same cycle: the start is ignored, because state is not IDLE. It is accepted on the next cycle if still high.
- reset_n asserted mid-frame: immediate return to reset values, with txd=1 asynchronously. The partial frame is abandoned. No tx_done pulse.

Optional Feature:
- Macro: RS_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, lasting 1 bit time.
  - txd = even parity (XOR of the accepted byte), computed at acceptance and stored in a register.
  - Frame = (1+8+1+P_STOP_BITS)*P_BAUD_DIV cycles.
- Undefined:
  - PARITY state and parity register are absent; DATA goes straight to STOP.
  - Frame = (1+8+P_STOP_BITS)*P_BAUD_DIV cycles.

Test Plan:
- Reset: hold reset_n=0 -> txd=1, tx_status=0, tx_done=0. Assert reset_n asynchronously mid-frame (P_BAUD_DIV=4, byte 8'h55, during bit 3) -> txd=1 and tx_status=0 before the next clk edge.
- Single byte (P_BAUD_DIV=4, tx_data=8'h41, tx_start pulsed 1 cycle):
  - txd sequence per 4-cycle bit: 0,1,0,0,0,0,0,1,0,1.
  - tx_status high for exactly 40 cycles; tx_done pulses once at the falling edge.
- Sequencer handshake model (poll status, pulse start, wait 1, re-poll), sending the 12 bytes of "01 23 45 67\n" (8'h30,8'h31,8'h20,…,8'h0A):
  - All 12 bytes decoded in order by the UART monitor.
  - The re-poll sees tx_status=1 every time.
- Busy collision: pulse tx_start with 8'hAA at cycle 10 of a 8'h0F frame (P_BAUD_DIV=4) -> only 8'h0F is transmitted; no second frame.
- tx_start held high, data 8'hFF, P_STOP_BITS=2, P_BAUD_DIV=4:
  - Consecutive frames of 44 cycles each.
  - Exactly 1 idle cycle with tx_status=0 between frames.
- With RS_TX_PARITY_EN and P_BAUD_DIV=4:
  - 8'h07 -> parity bit 1; 8'h03 -> parity bit 0.
  - Frame = 44 cycles.
  - Without the macro, the same stimulus gives 40-cycle frames.

Source files
------------

// File: rtl/rs232_tx.sv
// rs232_tx: byte-wide RS-232 serializer, 8 data bits LSB first, 1 or 2 stop bits,
// fixed integer clock divide. One byte is accepted per tx_start pulse while idle;
// tx_status is busy from acceptance until the frame ends and tx_done pulses once at the end.
//
// Optional feature: define RS_TX_PARITY_EN to insert an even-parity bit between the
// data bits and the stop bit(s). Without the macro the frame is plain 8N1/8N2.
//
// All outputs come straight from flops; no input reaches an output combinationally.

module rs232_tx #(
   parameter int unsigned P_BAUD_DIV  = 16'd434,  // clk cycles per bit, 2..65535
   parameter int unsigned P_STOP_BITS = 1         // 2 selects two stop bits, else one
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_status,
   output logic       tx_done,
   output logic       txd
);

   // Baud counter reload value: a bit lasts BaudReload..0, i.e. P_BAUD_DIV cycles.
   localparam logic [15:0] BaudReload = 16'(P_BAUD_DIV - 1);
   // Index of the final stop bit, counted in the (otherwise idle) bit counter.
   localparam logic [2:0]  LastStop   = (P_STOP_BITS == 2) ? 3'd1 : 3'd0;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop
`ifdef RS_TX_PARITY_EN
      , StParity
`endif
   } state_e;

   state_e      state_q, state_d;
   logic        txd_q, txd_d;
   logic        status_q, status_d;
   logic        done_q, done_d;
   logic [7:0]  shift_q, shift_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic        boundary;
`ifdef RS_TX_PARITY_EN
   logic        parity_q, parity_d;
`endif

   // Bit boundary: the edge on which the down-counter sits at zero.
   assign boundary = (baud_q == 16'd0);

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_d  = state_q;
      txd_d    = txd_q;
      status_d = status_q;
      done_d   = 1'b0;
      shift_d  = shift_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
`ifdef RS_TX_PARITY_EN
      parity_d = parity_q;
`endif

      // While a frame is in flight the counter free-runs and reloads at each boundary.
      if (state_q != StIdle) begin
         baud_d = boundary ? BaudReload : (baud_q - 16'd1);
      end

      unique case (state_q)
         StIdle: begin
            // Acceptance drives status and the start bit on the same edge so a
            // poll two cycles after the start pulse already sees busy.
            if (tx_start) begin
               state_d  = StStart;
               txd_d    = 1'b0;
               status_d = 1'b1;
               shift_d  = tx_data;
               baud_d   = BaudReload;
               bit_d    = 3'd0;
`ifdef RS_TX_PARITY_EN
               parity_d = ^tx_data;
`endif
            end
         end

         StStart: begin
            if (boundary) begin
               state_d = StData;
               txd_d   = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
            end
         end

         StData: begin
            if (boundary) begin
               if (bit_q == 3'd7) begin
                  bit_d = 3'd0;
`ifdef RS_TX_PARITY_EN
                  state_d = StParity;
                  txd_d   = parity_q;
`else
                  state_d = StStop;
                  txd_d   = 1'b1;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  txd_d   = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end

`ifdef RS_TX_PARITY_EN
         StParity: begin
            if (boundary) begin
               state_d = StStop;
               txd_d   = 1'b1;
            end
         end
`endif

         StStop: begin
            // The bit counter is reused to count stop bits.
            if (boundary) begin
               if (bit_q == LastStop) begin
                  state_d  = StIdle;
                  txd_d    = 1'b1;
                  status_d = 1'b0;
                  done_d   = 1'b1;
                  bit_d    = 3'd0;
                  baud_d   = 16'd0;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end

         default: begin
            state_d  = StIdle;
            txd_d    = 1'b1;
            status_d = 1'b0;
            bit_d    = 3'd0;
            baud_d   = 16'd0;
         end
      endcase
   end

   // State and registered outputs; reset forces the line idle-high immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         txd_q    <= 1'b1;
         status_q <= 1'b0;
         done_q   <= 1'b0;
         shift_q  <= 8'h00;
         baud_q   <= 16'd0;
         bit_q    <= 3'd0;
`ifdef RS_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         txd_q    <= txd_d;
         status_q <= status_d;
         done_q   <= done_d;
         shift_q  <= shift_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
`ifdef RS_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign txd       = txd_q;
   assign tx_status = status_q;
   assign tx_done   = done_q;

endmodule

// File: tb/tb_rs232_tx.sv
// tb_rs232_tx: scoreboard bench for rs232_tx. Stimulus pushes expected bytes into a queue;
// a UART monitor decodes the line of instance A and pops/compares each received frame.
// Instance B (two stop bits) is used for the held-start back-to-back test.

module tb_rs232_tx;

   logic       clk;
   logic       rst_n;
   logic       start_a, start_b;
   logic [7:0] data_a, data_b;
   logic       status_a, status_b;
   logic       done_a, done_b;
   logic       txd_a, txd_b;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   int         done_cnt_a = 0;

`ifdef RS_TX_PARITY_EN
   localparam int FrameA  = 44;
   localparam int FrameB  = 48;
   localparam int StopIdx = 10;
`else
   localparam int FrameA  = 40;
   localparam int FrameB  = 44;
   localparam int StopIdx = 9;
`endif

   rs232_tx #(.P_BAUD_DIV(4), .P_STOP_BITS(1)) u_dut_a (
      .clk       (clk),
      .reset_n   (rst_n),
      .tx_start  (start_a),
      .tx_data   (data_a),
      .tx_status (status_a),
      .tx_done   (done_a),
      .txd       (txd_a)
   );

   rs232_tx #(.P_BAUD_DIV(4), .P_STOP_BITS(2)) u_dut_b (
      .clk       (clk),
      .reset_n   (rst_n),
      .tx_start  (start_b),
      .tx_data   (data_b),
      .tx_status (status_b),
      .tx_done   (done_b),
      .txd       (txd_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Count consecutive negedge samples where the selected status equals lvl.
   task automatic run_len(input bit sel_b, input logic lvl, output int n);
      n = 0;
      while (((sel_b ? status_b : status_a) == lvl) && n < 500) begin
         n++;
         @(negedge clk);
      end
   endtask

   // Called at a negedge; returns on the first negedge after acceptance.
   task automatic send_a(input logic [7:0] b);
      start_a = 1'b1;
      data_a  = b;
      @(negedge clk);
      start_a = 1'b0;
      data_a  = 8'h00;
   endtask

   // UART monitor on instance A: samples each 4-cycle bit in its middle.
   bit         m_busy = 1'b0;
   int         m_cnt  = 0;
   int         bitn;
   logic [7:0] m_byte = 8'h00;
   logic [7:0] m_exp;
`ifdef RS_TX_PARITY_EN
   logic       m_par = 1'b0;
`endif

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_busy = 1'b0;
         end else begin
            if (done_a) done_cnt_a++;
            if (!m_busy) begin
               if (txd_a == 1'b0) begin
                  m_busy = 1'b1;
                  m_cnt  = 0;
               end
            end else begin
               m_cnt++;
               if (m_cnt % 4 == 2) begin
                  bitn = m_cnt / 4;
                  if (bitn >= 1 && bitn <= 8) m_byte[bitn-1] = txd_a;
`ifdef RS_TX_PARITY_EN
                  if (bitn == 9) m_par = txd_a;
`endif
                  if (bitn == StopIdx) begin
                     m_busy = 1'b0;
                     check("stop_bit", int'(txd_a), 1);
                     if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_frame: got byte %02h, required no frame", m_byte);
                     end else begin
                        m_exp = exp_q.pop_front();
                        check("rx_byte", int'(m_byte), int'(m_exp));
`ifdef RS_TX_PARITY_EN
                        check("parity_bit", int'(m_par), int'(^m_exp));
`endif
                     end
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   logic [7:0] msg [12];
   logic [7:0] par_bytes [2];
   int         len;
   int         d0;
   int         cnt;

   initial begin : stimulus
      msg = '{8'h30, 8'h31, 8'h20, 8'h32, 8'h33, 8'h20,
              8'h34, 8'h35, 8'h20, 8'h36, 8'h37, 8'h0A};
      par_bytes = '{8'h07, 8'h03};
      rst_n   = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      data_a  = 8'h00;
      data_b  = 8'h00;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_txd_a", int'(txd_a), 1);
      check("rst_status_a", int'(status_a), 0);
      check("rst_done_a", int'(done_a), 0);
      check("rst_txd_b", int'(txd_b), 1);
      check("rst_status_b", int'(status_b), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single byte 8'h41: 40-cycle busy, one done pulse at the fall
      exp_q.push_back(8'h41);
      d0 = done_cnt_a;
      send_a(8'h41);
      run_len(1'b0, 1'b1, len);
      check("frame_len_41", len, FrameA);
      check("done_at_fall", int'(done_a), 1);
      @(negedge clk);
      check("done_width", int'(done_a), 0);
      check("done_count", done_cnt_a - d0, 1);
      repeat (3) @(negedge clk);

      // Sequencer handshake: poll low, pulse start, re-poll two cycles later
      for (int i = 0; i < 12; i++) begin
         cnt = 0;
         while (status_a && cnt < 200) begin
            cnt++;
            @(negedge clk);
         end
         check("poll_idle", int'(status_a), 0);
         exp_q.push_back(msg[i]);
         send_a(msg[i]);
         @(negedge clk);
         check("repoll_busy", int'(status_a), 1);
      end
      run_len(1'b0, 1'b1, len);
      repeat (4) @(negedge clk);

      // Busy collision: 8'hAA at cycle 10 of an 8'h0F frame is dropped
      exp_q.push_back(8'h0F);
      send_a(8'h0F);
      repeat (9) @(negedge clk);
      start_a = 1'b1;
      data_a  = 8'hAA;
      @(negedge clk);
      start_a = 1'b0;
      data_a  = 8'h00;
      run_len(1'b0, 1'b1, len);
      check("collision_rest_len", len, FrameA - 10);
      cnt = 0;
      repeat (60) begin
         @(negedge clk);
         if (status_a) cnt++;
      end
      check("no_second_frame", cnt, 0);

      // Parity bytes (frame length depends on the build)
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(par_bytes[i]);
         send_a(par_bytes[i]);
         run_len(1'b0, 1'b1, len);
         check("parity_frame_len", len, FrameA);
         repeat (3) @(negedge clk);
      end

      // tx_start held high on the two-stop-bit instance
      start_b = 1'b1;
      data_b  = 8'hFF;
      @(negedge clk);
      run_len(1'b1, 1'b1, len);
      check("held_frame1_len", len, FrameB);
      check("held_gap_txd", int'(txd_b), 1);
      run_len(1'b1, 1'b0, len);
      check("held_gap_len", len, 1);
      start_b = 1'b0;
      run_len(1'b1, 1'b1, len);
      check("held_frame2_len", len, FrameB);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (status_b) cnt++;
      end
      check("held_released_idle", cnt, 0);

      // Asynchronous reset during data bit 3 of 8'h55
      send_a(8'h55);
      repeat (17) @(negedge clk);
      check("abort_bit3_txd", int'(txd_a), 0);
      check("abort_busy", int'(status_a), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_txd", int'(txd_a), 1);
      check("async_rst_status", int'(status_a), 0);
      check("async_rst_done", int'(done_a), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      d0 = done_cnt_a;
      repeat (60) @(negedge clk);
      check("abort_no_done", done_cnt_a - d0, 0);
      check("abort_line_idle", int'(txd_a), 1);

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
